digest_serializer: RTL

DIGEST_SERIALIZER -- requirements
Module: digest_serializer

---
 rtl/digest_serializer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/digest_serializer.sv
`default_nettype none
// ============================================================================
// Module   : digest_serializer
// Purpose  : Streams the first NWORDS 64-bit lanes of a Keccak permutation
//            result as digest words. A one-deep pending slot lets results
//            arrive back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module digest_serializer #(
    parameter int NWORDS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pushin,
    input  logic [1599:0] din,
    input  logic [7:0]    tagin,
    input  logic          stopin,
    output logic [63:0]   dout,
    output logic [7:0]    tagout,
    output logic [4:0]    dix,
    output logic          pushout,
    output logic          lastout,
    output logic          overflow
);

    localparam int         DW     = NWORDS * 64;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam logic [4:0] C_LAST  = 5'(NWORDS - 1);

    logic [0:0]    state_q, state_d;
    logic [DW-1:0] act_data_q, act_data_d;
    logic [7:0]    act_tag_q, act_tag_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    logic [7:0]    pend_tag_q, pend_tag_d;
    logic          pend_vld_q, pend_vld_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic          w_send;
    logic          w_xfer;
    logic          w_final;
    logic [63:0]   w_lane;
    logic          w_din_unused;

    // Lanes at and above NWORDS are never stored, so they cannot reach dout.
    assign w_din_unused = ^din;

    assign w_send  = (state_q == ST_SEND);
    assign w_xfer  = w_send && !stopin;
    assign w_final = w_xfer && (cnt_q == C_LAST);

    always_comb begin
        state_d     = state_q;
        act_data_d  = act_data_q;
        act_tag_d   = act_tag_q;
        pend_data_d = pend_data_q;
        pend_tag_d  = pend_tag_q;
        pend_vld_d  = pend_vld_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (pushin) begin
                    act_data_d = din[DW-1:0];
                    act_tag_d  = tagin;
                    cnt_d      = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_final) begin
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        act_data_d = pend_data_q;
                        act_tag_d  = pend_tag_q;
                        pend_vld_d = pushin;
                        if (pushin) begin
                            pend_data_d = din[DW-1:0];
                            pend_tag_d  = tagin;
                        end
                    end else if (pushin) begin
                        act_data_d = din[DW-1:0];
                        act_tag_d  = tagin;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                    // A result arriving with both slots full is lost.
                    if (pushin) begin
                        if (!pend_vld_q) begin
                            pend_data_d = din[DW-1:0];
                            pend_tag_d  = tagin;
                            pend_vld_d  = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            act_data_q  <= '0;
            act_tag_q   <= '0;
            pend_data_q <= '0;
            pend_tag_q  <= '0;
            pend_vld_q  <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_data_q  <= act_data_d;
            act_tag_q   <= act_tag_d;
            pend_data_q <= pend_data_d;
            pend_tag_q  <= pend_tag_d;
            pend_vld_q  <= pend_vld_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        w_lane = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (cnt_q == 5'(i)) begin
                w_lane = act_data_q[i*64 +: 64];
            end
        end
    end

    assign pushout  = w_send;
    assign dout     = w_send ? w_lane : 64'd0;
    assign tagout   = w_send ? act_tag_q : 8'd0;
    assign dix      = cnt_q;
    assign lastout  = w_send && (cnt_q == C_LAST);
    assign overflow = ovf_q;

endmodule
`default_nettype wire
